// File: rtl/jb_dl_dfe_cfg_seq.sv
// Table-driven AXI4-Lite register write sequencer for DFE configuration.
// Optional readback verification of every write: define JB_DL_DFE_CFG_SEQ_READBACK_EN.
module jb_dl_dfe_cfg_seq #(
  parameter int AXI_ADDR_WIDTH = 13,
  parameter int AXI_DATA_WIDTH = 32,
  parameter int TBL_DEPTH      = 16,
  parameter int TIMEOUT_CYC    = 256
) (
  input  logic                          clk,
  input  logic                          srst_n,
  input  logic                          tbl_we,
  input  logic [$clog2(TBL_DEPTH)-1:0]  tbl_idx,
  input  logic [AXI_ADDR_WIDTH-1:0]     tbl_addr,
  input  logic [AXI_DATA_WIDTH-1:0]     tbl_data,
  input  logic [$clog2(TBL_DEPTH):0]    num_entries,
  input  logic                          start,
  input  logic                          abort,
  output logic                          busy,
  output logic                          done,
  output logic                          error,
  output logic [$clog2(TBL_DEPTH)-1:0]  err_idx,
  output logic [AXI_ADDR_WIDTH-1:0]     awaddr,
  output logic                          awvalid,
  input  logic                          awready,
  output logic [AXI_DATA_WIDTH-1:0]     wdata,
  output logic [AXI_DATA_WIDTH/8-1:0]   wstrb,
  output logic                          wvalid,
  input  logic                          wready,
  input  logic [1:0]                    bresp,
  input  logic                          bvalid,
  output logic                          bready
`ifdef JB_DL_DFE_CFG_SEQ_READBACK_EN
  ,
  output logic [AXI_ADDR_WIDTH-1:0]     araddr,
  output logic                          arvalid,
  input  logic                          arready,
  input  logic [AXI_DATA_WIDTH-1:0]     rdata,
  input  logic [1:0]                    rresp,
  input  logic                          rvalid,
  output logic                          rready
`endif
);
  localparam int IW = $clog2(TBL_DEPTH);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

`ifdef JB_DL_DFE_CFG_SEQ_READBACK_EN
  typedef enum logic [2:0] {S_IDLE, S_WR, S_BRESP, S_NEXT, S_FINISH, S_RD, S_RRESP} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_WR, S_BRESP, S_NEXT, S_FINISH} state_t;
`endif

  logic [AXI_ADDR_WIDTH-1:0] tbl_addr_q [TBL_DEPTH];
  logic [AXI_DATA_WIDTH-1:0] tbl_data_q [TBL_DEPTH];

  state_t                    state_q, state_d;
  logic [IW-1:0]             idx_q, idx_d, err_idx_q, err_idx_d;
  logic [IW:0]               num_q, num_d;
  logic [TW-1:0]             cnt_q, cnt_d;
  logic                      aw_done_q, w_done_q, error_q, error_d;
  logic [AXI_ADDR_WIDTH-1:0] cur_addr_q, cur_addr_d;
  logic [AXI_DATA_WIDTH-1:0] cur_data_q, cur_data_d;
  logic                      aw_hs, w_hs, tmo;

  // Table has no reset so contents survive srst_n.
  always_ff @(posedge clk) begin
    if (tbl_we) begin
      tbl_addr_q[tbl_idx] <= tbl_addr;
      tbl_data_q[tbl_idx] <= tbl_data;
    end
  end

  assign aw_hs = awvalid & awready;
  assign w_hs  = wvalid & wready;
  assign tmo   = (cnt_q == TW'(TIMEOUT_CYC - 1));

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    num_d     = num_q;
    error_d   = error_q;
    err_idx_d = err_idx_q;
    case (state_q)
      S_IDLE: if (start) begin
        num_d = num_entries;
        idx_d = '0;
        if (num_entries != '0) begin
          error_d = 1'b0;
          state_d = S_WR;
        end else begin
          state_d = S_FINISH;
        end
      end
      S_WR: begin
        if (abort) state_d = S_FINISH;
        else if ((aw_done_q | aw_hs) && (w_done_q | w_hs)) state_d = S_BRESP;
        else if (tmo) begin error_d = 1'b1; err_idx_d = idx_q; state_d = S_FINISH; end
      end
      S_BRESP: begin
        if (abort) state_d = S_FINISH;
        else if (bvalid) begin
          if (bresp == 2'b00) begin
`ifdef JB_DL_DFE_CFG_SEQ_READBACK_EN
            state_d = S_RD;
`else
            state_d = S_NEXT;
`endif
          end else begin
            error_d = 1'b1; err_idx_d = idx_q; state_d = S_FINISH;
          end
        end else if (tmo) begin error_d = 1'b1; err_idx_d = idx_q; state_d = S_FINISH; end
      end
`ifdef JB_DL_DFE_CFG_SEQ_READBACK_EN
      S_RD: begin
        if (abort) state_d = S_FINISH;
        else if (arready) state_d = S_RRESP;
        else if (tmo) begin error_d = 1'b1; err_idx_d = idx_q; state_d = S_FINISH; end
      end
      S_RRESP: begin
        if (abort) state_d = S_FINISH;
        else if (rvalid) begin
          if (rresp == 2'b00 && rdata == cur_data_q) state_d = S_NEXT;
          else begin error_d = 1'b1; err_idx_d = idx_q; state_d = S_FINISH; end
        end else if (tmo) begin error_d = 1'b1; err_idx_d = idx_q; state_d = S_FINISH; end
      end
`endif
      S_NEXT: begin
        if (abort) state_d = S_FINISH;
        else if (({1'b0, idx_q} + 1'b1) < num_q) begin
          idx_d   = idx_q + 1'b1;
          state_d = S_WR;
        end else begin
          state_d = S_FINISH;
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Snapshot the entry on WR entry so table writes never disturb an issued beat.
  always_comb begin
    cur_addr_d = cur_addr_q;
    cur_data_d = cur_data_q;
    if (state_d == S_WR && state_q != S_WR) begin
      cur_addr_d = tbl_addr_q[idx_d];
      cur_data_d = tbl_data_q[idx_d];
    end
    cnt_d = (state_d != state_q) ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!srst_n) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      num_q      <= '0;
      cnt_q      <= '0;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
      error_q    <= 1'b0;
      err_idx_q  <= '0;
      cur_addr_q <= '0;
      cur_data_q <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      num_q      <= num_d;
      cnt_q      <= cnt_d;
      aw_done_q  <= (state_q == S_WR) && (aw_done_q | aw_hs);
      w_done_q   <= (state_q == S_WR) && (w_done_q | w_hs);
      error_q    <= error_d;
      err_idx_q  <= err_idx_d;
      cur_addr_q <= cur_addr_d;
      cur_data_q <= cur_data_d;
    end
  end

  assign busy    = (state_q != S_IDLE);
  assign done    = (state_q == S_FINISH);
  assign error   = error_q;
  assign err_idx = err_idx_q;
  assign awaddr  = cur_addr_q;
  assign awvalid = (state_q == S_WR) && !aw_done_q;
  assign wdata   = cur_data_q;
  assign wstrb   = '1;
  assign wvalid  = (state_q == S_WR) && !w_done_q;
  assign bready  = (state_q == S_BRESP);
`ifdef JB_DL_DFE_CFG_SEQ_READBACK_EN
  assign araddr  = cur_addr_q;
  assign arvalid = (state_q == S_RD);
  assign rready  = (state_q == S_RRESP);
`endif
endmodule
